// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the fetch PC, requests sequential words, buffers them in a prefetch FIFO.
// Latency: a word acked at edge N is visible on Instr_F/PCF after edge N; redirect to first valid is 2 cycles with zero-wait memory.
// Backpressure: instr_ready low holds the head; new requests are issued only while FIFO occupancy plus the outstanding request stays below DEPTH.
module fetch_prefetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] Instr_F,
   output logic [31:0] PCF
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   // Prefetch storage: PC and instruction word kept side by side per entry.
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   // Fetch PC of the next word to be pushed, and the flag marking an in-flight word as stale.
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_next;
   logic          drop;

   // Handshake qualifiers.
   logic          xfer;
   logic          req_hold;
   logic          req_next;
   logic          push;
   logic          pop;

   // A transfer only happens while a request is actually presented.
   assign xfer     = imem_req & imem_ack;
   // A request presented but not yet accepted must keep its address.
   assign req_hold = imem_req & ~imem_ack;
   // Stale words (drop set, or acked in a redirect cycle) never enter the FIFO.
   assign push     = xfer & ~drop & ~redirect;
   // A redirect wipes the FIFO, so any pop in that cycle is meaningless.
   assign pop      = instr_valid & instr_ready & ~redirect;

   // Occupancy after this edge; drives both the count register and request gating.
   always_comb begin
      count_next = count;
      if (redirect) begin
         count_next = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
         endcase
      end
   end

   // Fetch PC after this edge: redirect target wins, otherwise advance on every accepted word.
   always_comb begin
      fetch_pc_next = fetch_pc;
      if (redirect) begin
         fetch_pc_next = redirect_pc;
      end else if (push) begin
         fetch_pc_next = fetch_pc + 32'd4;
      end
   end

   // Keep a pending request up; otherwise launch a new one only if its word is sure to fit.
   assign req_next = req_hold | (count_next < CW'(DEPTH));

   // Fetch PC and stale-word tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         drop     <= 1'b0;
      end else begin
         fetch_pc <= fetch_pc_next;
         if (redirect && req_hold) begin
            drop <= 1'b1;
         end else if (xfer) begin
            drop <= 1'b0;
         end
      end
   end

   // Registered request and address; the address is frozen while a request waits for ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         imem_req <= req_next;
         if (!req_hold) begin
            imem_addr <= fetch_pc_next;
         end
      end
   end

   // FIFO pointers and occupancy; a redirect returns everything to the empty state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
      end
   end

   // Entry write; contents need no reset since occupancy qualifies every read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         data_mem[wr_ptr] <= imem_rdata;
      end
   end

   // Head presentation; outputs read as zero whenever nothing is buffered.
   always_comb begin
      instr_valid = (count != '0);
      Instr_F     = 32'd0;
      PCF         = 32'd0;
      if (instr_valid) begin
         Instr_F = data_mem[rd_ptr];
         PCF     = pc_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-level reference model, directed scenarios and randomized traffic.
// Each step drives inputs, advances one clock, updates the model and compares 1 time unit after the edge.
// Memory is modelled as a pure function of the address, so every delivered word can be re-derived.
module tb_fetch_prefetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] Instr_F;
   logic [31:0] PCF;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .Instr_F     (Instr_F),
      .PCF         (PCF)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] w;
   } ent_t;

   // Reference model: buffered words, next PC to fetch, request in flight, stale flag.
   ent_t        q[$];
   logic [31:0] m_pc;
   bit          m_pend;
   logic [31:0] m_addr;
   bit          m_drop;

   // Program-order tracker: the next PC the core should consume.
   logic [31:0] exp_next;
   bit          exp_known = 1'b0;

   bit          prev_req;
   bit          prev_ack;
   logic [31:0] prev_addr;

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit rst, input bit rd, input logic [31:0] rpc,
                               input bit ack, input bit rdy);
      bit xfer;
      bit pop;
      xfer = m_pend && ack;
      pop  = (q.size() != 0) && rdy && !rd;
      if (rst) begin
         q.delete();
         m_pc   = RESET_PC;
         m_pend = 1'b0;
         m_drop = 1'b0;
         m_addr = RESET_PC;
         return;
      end
      if (rd) begin
         q.delete();
         if (xfer) begin
            m_pend = 1'b0;
            m_drop = 1'b0;
         end else if (m_pend) begin
            m_drop = 1'b1;
         end
         m_pc = rpc;
      end else begin
         if (pop) void'(q.pop_front());
         if (xfer) begin
            m_pend = 1'b0;
            if (m_drop) begin
               m_drop = 1'b0;
            end else begin
               q.push_back('{pc: m_pc, w: word_of(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      if (!m_pend) begin
         m_pend = (q.size() < DEPTH);
         m_addr = m_pc;
      end
   endtask

   task automatic compare(input bit rst);
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_pend});
      if (m_pend) chk("imem_addr", imem_addr, m_addr);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, (q.size() != 0)});
      chk("PCF", PCF, (q.size() != 0) ? q[0].pc : 32'd0);
      chk("Instr_F", Instr_F, (q.size() != 0) ? q[0].w : 32'd0);
      if (instr_valid) chk("word_integrity", Instr_F, word_of(PCF));
      if (!rst && prev_req && !prev_ack) begin
         chk("req_held", {31'd0, imem_req}, 32'd1);
         chk("addr_stable", imem_addr, prev_addr);
      end
   endtask

   task automatic step(input bit rst, input bit rd, input logic [31:0] rpc,
                       input bit ack, input bit rdy);
      reset       = rst;
      redirect    = rd;
      redirect_pc = rpc;
      imem_ack    = ack;
      instr_ready = rdy;
      imem_rdata  = word_of(imem_addr);
      if (!rst && !rd && instr_valid && rdy) begin
         if (exp_known) chk("consume_order", PCF, exp_next);
         exp_next  = PCF + 32'd4;
         exp_known = 1'b1;
      end
      prev_req  = imem_req;
      prev_ack  = ack;
      prev_addr = imem_addr;
      @(posedge clk);
      model_update(rst, rd, rpc, ack, rdy);
      if (rst) begin
         exp_next  = RESET_PC;
         exp_known = 1'b1;
      end else if (rd) begin
         exp_next  = rpc;
         exp_known = 1'b1;
      end
      #1;
      compare(rst);
   endtask

   initial begin
      int ack_pct;
      int rdy_pct;
      bit r_rd;
      bit r_rst;
      logic [31:0] r_pc;

      // Reset.
      step(1, 0, 32'd0, 1, 1);
      step(1, 0, 32'd0, 1, 1);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", Instr_F, 32'd0);
      chk("rst_pcf", PCF, 32'd0);

      // Zero-wait streaming.
      step(0, 0, 32'd0, 1, 1);
      chk("s1_req", {31'd0, imem_req}, 32'd1);
      chk("s1_addr", imem_addr, 32'h0);
      step(0, 0, 32'd0, 1, 1);
      chk("s2_pcf", PCF, 32'h0);
      chk("s2_instr", Instr_F, word_of(32'h0));
      chk("s2_addr", imem_addr, 32'h4);
      for (int i = 0; i < 8; i++) step(0, 0, 32'd0, 1, 1);

      // Core stall: FIFO fills and requests stop, then drain.
      for (int i = 0; i < 10; i++) step(0, 0, 32'd0, 1, 0);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      for (int i = 0; i < 8; i++) step(0, 0, 32'd0, 1, 1);

      // Slow memory: ack every third cycle.
      for (int i = 0; i < 18; i++) step(0, 0, 32'd0, (i % 3) == 2, 1);

      // Fill FIFO with 0x10..0x1C, then redirect to 0x200.
      step(0, 1, 32'h10, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 1, 0);
      chk("fill_pcf", PCF, 32'h10);
      chk("fill_req", {31'd0, imem_req}, 32'd0);
      step(0, 1, 32'h200, 0, 1);
      chk("redir_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h200);
      step(0, 0, 32'd0, 1, 0);
      chk("redir_pcf", PCF, 32'h200);
      chk("redir_instr", Instr_F, word_of(32'h200));

      // Redirect while a request is pending: the in-flight word is discarded.
      step(0, 1, 32'h40, 1, 1);
      chk("p_addr40", imem_addr, 32'h40);
      step(0, 1, 32'h80, 0, 1);
      chk("drop_hold_addr", imem_addr, 32'h40);
      step(0, 0, 32'd0, 0, 1);
      chk("drop_hold_req", {31'd0, imem_req}, 32'd1);
      step(0, 0, 32'd0, 1, 1);
      chk("drop_valid", {31'd0, instr_valid}, 32'd0);
      chk("drop_next_addr", imem_addr, 32'h80);
      step(0, 0, 32'd0, 1, 1);
      chk("drop_pcf", PCF, 32'h80);

      // Redirect coinciding with ack and a ready core, then reset mid-request.
      step(0, 1, 32'h300, 1, 1);
      chk("rack_valid", {31'd0, instr_valid}, 32'd0);
      chk("rack_addr", imem_addr, 32'h300);
      step(0, 0, 32'd0, 0, 1);
      step(1, 0, 32'd0, 0, 1);
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      step(0, 0, 32'd0, 0, 1);
      chk("post_rst_addr", imem_addr, RESET_PC);

      // Randomized traffic with varying memory and core behaviour.
      for (int i = 0; i < 3000; i++) begin
         case ((i / 250) % 4)
            0: begin ack_pct = 100; rdy_pct = 90; end
            1: begin ack_pct = 60;  rdy_pct = 40; end
            2: begin ack_pct = 30;  rdy_pct = 80; end
            default: begin ack_pct = 90; rdy_pct = 15; end
         endcase
         r_rst = ($urandom_range(399) == 0);
         r_rd  = ($urandom_range(29) == 0);
         r_pc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
         step(r_rst, r_rd, r_pc,
              ($urandom_range(99) < ack_pct), ($urandom_range(99) < rdy_pct));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
